fpu_wb_sched: RTL and testbench

Writeback-slot scheduler for the three FPU issue lanes (u1/u3/u5). It keeps a per-lane reservation table of future result-bus cycles. It grants an issue request only when the op's fixed latency lands on a free writeback slot. It also sequences the single non-pipelined iterative unit (div/sqrt, lane 0 only) and arbitrates the result bus for an external writer (convert/ALT path). It sits between the FP issue queue and the FPU datapath, driving the per-lane op and enable inputs and the result-valid strobes.

---
 rtl/fpu_wb_sched_pkg.sv | 22 ++
 rtl/fpu_wb_resv_row.sv | 70 +++++++
 rtl/fpu_wb_sched.sv | 106 ++++++++++
 tb/tb_fpu_wb_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_wb_sched_pkg.sv
// Shared FPU writeback-scheduler types: latency classes, fixed latencies,
// iterative-unit defaults and FSM encoding.
package fpu_wb_sched_pkg;

    typedef enum logic [1:0] {
        LAT2 = 2'd0,
        LAT3 = 2'd1,
        LAT4 = 2'd2,
        ITER = 2'd3
    } lat_cls_e;

    localparam int unsigned LAT2_CYC     = 2;
    localparam int unsigned LAT3_CYC     = 3;
    localparam int unsigned LAT4_CYC     = 4;
    localparam int unsigned ITER_LAT_DEF = 12;

    typedef enum logic {
        IT_IDLE = 1'b0,
        IT_RUN  = 1'b1
    } iter_state_e;

endpackage

// File: rtl/fpu_wb_resv_row.sv
// One lane's writeback reservation row: future bus-ownership shift register,
// issue/external grant decisions and the registered result-valid strobe.
module fpu_wb_resv_row
    import fpu_wb_sched_pkg::*;
#(
    parameter int unsigned ITER_LAT = ITER_LAT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       req_vld_i,
    input  logic [1:0] req_lat_i,
    input  logic       iter_ok_i,
    input  logic       ext_req_i,
    output logic       gnt_o,
    output logic       ext_gnt_o,
    output logic       wb_vld_o
);

    logic [ITER_LAT:1] res_q, res_d;
    logic              wb_vld_q, wb_vld_d;
    logic              slot_busy;
    logic              class_ok;

    always_comb begin
        slot_busy = 1'b0;
        class_ok  = 1'b1;
        case (lat_cls_e'(req_lat_i))
            LAT2:    slot_busy = res_q[LAT2_CYC];
            LAT3:    slot_busy = res_q[LAT3_CYC];
            LAT4:    slot_busy = res_q[LAT4_CYC];
            default: begin
                slot_busy = res_q[ITER_LAT];
                class_ok  = iter_ok_i;
            end
        endcase

        gnt_o     = rst_ni & ~flush_i & req_vld_i & ~slot_busy & class_ok;
        ext_gnt_o = rst_ni & ~flush_i & ext_req_i & ~res_q[1];

        // The new op lands one slot below L because the row shifts this cycle.
        res_d = {1'b0, res_q[ITER_LAT:2]};
        if (gnt_o) begin
            case (lat_cls_e'(req_lat_i))
                LAT2:    res_d[LAT2_CYC-1] = 1'b1;
                LAT3:    res_d[LAT3_CYC-1] = 1'b1;
                LAT4:    res_d[LAT4_CYC-1] = 1'b1;
                default: res_d[ITER_LAT-1] = 1'b1;
            endcase
        end
        if (flush_i) begin
            res_d = '0;
        end

        wb_vld_d = ~flush_i & (res_q[1] | ext_gnt_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_q    <= '0;
            wb_vld_q <= 1'b0;
        end else begin
            res_q    <= res_d;
            wb_vld_q <= wb_vld_d;
        end
    end

    assign wb_vld_o = wb_vld_q;

endmodule

// File: rtl/fpu_wb_sched.sv
// Writeback-slot scheduler for the three FPU issue lanes, including the
// lane-0 iterative (div/sqrt) unit occupancy FSM.
module fpu_wb_sched
    import fpu_wb_sched_pkg::*;
#(
    parameter int unsigned OPW      = 21,
    parameter int unsigned ITER_LAT = ITER_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req_vld,
    input  logic [3*OPW-1:0] req_op,
    input  logic [5:0]       req_lat,
    output logic [2:0]       req_gnt,
    output logic [2:0]       iss_vld,
    output logic [3*OPW-1:0] iss_op,
    output logic [2:0]       wb_vld,
    input  logic [2:0]       ext_wb_req,
    output logic [2:0]       ext_wb_gnt,
    output logic             iter_busy,
    input  logic             flush
);

    localparam int unsigned CNT_W = $clog2(ITER_LAT);

    logic [2:0]       iter_ok;
    logic [2:0]       iss_vld_q, iss_vld_d;
    logic [3*OPW-1:0] iss_op_q, iss_op_d;
    iter_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             iter_start;

    assign iter_busy = (state_q == IT_RUN);
    // Only lane 0 hosts the iterative unit.
    assign iter_ok   = {2'b00, ~iter_busy};

    for (genvar g = 0; g < 3; g++) begin : g_lane
        fpu_wb_resv_row #(
            .ITER_LAT (ITER_LAT)
        ) u_row (
            .clk_i     (clk),
            .rst_ni    (rst),
            .flush_i   (flush),
            .req_vld_i (req_vld[g]),
            .req_lat_i (req_lat[2*g +: 2]),
            .iter_ok_i (iter_ok[g]),
            .ext_req_i (ext_wb_req[g]),
            .gnt_o     (req_gnt[g]),
            .ext_gnt_o (ext_wb_gnt[g]),
            .wb_vld_o  (wb_vld[g])
        );
    end

    always_comb begin
        iss_vld_d = req_gnt;
        iss_op_d  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (req_gnt[i]) begin
                iss_op_d[i*OPW +: OPW] = req_op[i*OPW +: OPW];
            end
        end
    end

    assign iter_start = req_gnt[0] & (lat_cls_e'(req_lat[1:0]) == ITER);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IT_IDLE: begin
                if (iter_start) begin
                    state_d = IT_RUN;
                    cnt_d   = CNT_W'(ITER_LAT - 1);
                end
            end
            default: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IT_IDLE;
                end
            end
        endcase
        if (flush) begin
            state_d = IT_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IT_IDLE;
            cnt_q     <= '0;
            iss_vld_q <= '0;
            iss_op_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            iss_vld_q <= iss_vld_d;
            iss_op_q  <= iss_op_d;
        end
    end

    assign iss_vld = iss_vld_q;
    assign iss_op  = iss_op_q;

endmodule

// File: tb/tb_fpu_wb_sched.sv
// Self-checking bench: per-lane writeback calendar model plus directed cases.
module tb_fpu_wb_sched;

    localparam int OPW = 21;
    localparam int IL  = 12;
    localparam int NC  = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req_vld;
    logic [3*OPW-1:0] req_op;
    logic [5:0]       req_lat;
    logic [2:0]       req_gnt;
    logic [2:0]       iss_vld;
    logic [3*OPW-1:0] iss_op;
    logic [2:0]       wb_vld;
    logic [2:0]       ext_wb_req;
    logic [2:0]       ext_wb_gnt;
    logic             iter_busy;
    logic             flush;

    always #5 clk = ~clk;

    fpu_wb_sched #(
        .OPW      (OPW),
        .ITER_LAT (IL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_op     (req_op),
        .req_lat    (req_lat),
        .req_gnt    (req_gnt),
        .iss_vld    (iss_vld),
        .iss_op     (iss_op),
        .wb_vld     (wb_vld),
        .ext_wb_req (ext_wb_req),
        .ext_wb_gnt (ext_wb_gnt),
        .iter_busy  (iter_busy),
        .flush      (flush)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int iter_end = -1;

    // Calendar: wb_exp[lane][c] = lane's bus carries a result in cycle c.
    bit               wb_exp [3][NC];
    bit [2:0]         iss_vld_exp [NC];
    bit [3*OPW-1:0]   iss_op_exp [NC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] c);
        case (c)
            2'd0:    return 2;
            2'd1:    return 3;
            2'd2:    return 4;
            default: return IL;
        endcase
    endfunction

    task automatic cycle(input logic r, input logic [2:0] v, input logic [5:0] l,
                         input logic [2:0] e, input logic f, input logic [3*OPW-1:0] op);
        logic [2:0] eg;
        logic [2:0] ee;
        int         lt;
        @(posedge clk);
        #1;
        cyc++;
        chk("wb_vld", wb_vld, {wb_exp[2][cyc], wb_exp[1][cyc], wb_exp[0][cyc]});
        chk("iss_vld", iss_vld, iss_vld_exp[cyc]);
        for (int i = 0; i < 3; i++) begin
            if (iss_vld_exp[cyc][i])
                chk("iss_op", iss_op[i*OPW +: OPW], iss_op_exp[cyc][i*OPW +: OPW]);
        end
        chk("iter_busy", iter_busy, cyc <= iter_end);

        rst = r; req_vld = v; req_lat = l; ext_wb_req = e; flush = f; req_op = op;
        #2;
        if (!r) begin
            chk("rst_outs", {wb_vld, iss_vld, iter_busy}, 7'd0);
            iter_end = -1;
        end
        eg = '0;
        ee = '0;
        for (int i = 0; i < 3; i++) begin
            lt = lat_of(l[2*i +: 2]);
            eg[i] = r && !f && v[i] && !wb_exp[i][cyc+lt] &&
                    (l[2*i +: 2] != 2'd3 || (i == 0 && cyc > iter_end));
            ee[i] = r && !f && e[i] && !wb_exp[i][cyc+1];
        end
        chk("req_gnt", req_gnt, eg);
        chk("ext_wb_gnt", ext_wb_gnt, ee);

        if (f || !r) begin
            for (int k = cyc + 1; k <= cyc + IL + 2; k++)
                for (int i = 0; i < 3; i++) wb_exp[i][k] = 1'b0;
            if (iter_end > cyc) iter_end = cyc;
        end
        iss_op_exp[cyc+1] = '0;
        for (int i = 0; i < 3; i++) begin
            if (eg[i]) begin
                wb_exp[i][cyc + lat_of(l[2*i +: 2])] = 1'b1;
                iss_op_exp[cyc+1][i*OPW +: OPW] = op[i*OPW +: OPW];
            end
            if (ee[i]) wb_exp[i][cyc+1] = 1'b1;
        end
        if (eg[0] && l[1:0] == 2'd3) iter_end = cyc + IL - 1;
        iss_vld_exp[cyc+1] = eg;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 3'b000, 6'd0, 3'b000, 1'b0, '0);
    endtask

    logic [63:0]      rnd;
    logic [3*OPW-1:0] op_a;
    logic [2:0]       rv;
    logic [5:0]       rl;
    logic [2:0]       re;

    initial begin
        rst = 1'b0; req_vld = 3'b111; req_lat = 6'd0; req_op = '1;
        ext_wb_req = 3'b111; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wb_vld", wb_vld, 3'b000);
        chk("reset_iss_vld", iss_vld, 3'b000);
        chk("reset_iss_op", iss_op, 63'd0);
        chk("reset_iter_busy", iter_busy, 1'b0);
        chk("reset_gnt", {req_gnt, ext_wb_gnt}, 6'd0);
        idle(2);

        // Lane 1: LAT2 then LAT4 back to back.
        op_a = '0;
        op_a[OPW +: OPW] = 21'h12345;
        cycle(1'b1, 3'b010, 6'b00_00_00, 3'b000, 1'b0, op_a);
        chk("d1_gnt_t0", req_gnt, 3'b010);
        cycle(1'b1, 3'b010, 6'b00_10_00, 3'b000, 1'b0, '0);
        chk("d1_gnt_t1", req_gnt, 3'b010);
        chk("d1_iss_t1", iss_vld[1], 1'b1);
        chk("d1_op_t1", iss_op[OPW +: OPW], 21'h12345);
        idle(1);
        chk("d1_wb_t2", wb_vld[1], 1'b1);
        chk("d1_iss_t2", iss_vld[1], 1'b1);
        idle(1);
        chk("d1_wb_t3", wb_vld[1], 1'b0);
        idle(1);
        chk("d1_wb_t4", wb_vld[1], 1'b0);
        idle(1);
        chk("d1_wb_t5", wb_vld[1], 1'b1);
        idle(14);

        // Lane 0: LAT4 blocks a LAT2 two cycles later.
        cycle(1'b1, 3'b001, 6'b00_00_10, 3'b000, 1'b0, '0);
        chk("d2_gnt_t0", req_gnt, 3'b001);
        idle(1);
        cycle(1'b1, 3'b001, 6'b00_00_00, 3'b000, 1'b0, '0);
        chk("d2_gnt_t2", req_gnt, 3'b000);
        cycle(1'b1, 3'b001, 6'b00_00_00, 3'b000, 1'b0, '0);
        chk("d2_gnt_t3", req_gnt, 3'b001);
        idle(1);
        chk("d2_wb_t4", wb_vld[0], 1'b1);
        idle(1);
        chk("d2_wb_t5", wb_vld[0], 1'b1);
        idle(1);
        chk("d2_wb_t6", wb_vld[0], 1'b0);
        idle(14);

        // Lane 2: external writer collides with LAT3, then retries.
        idle(1);
        cycle(1'b1, 3'b100, 6'b01_00_00, 3'b000, 1'b0, '0);
        chk("d3_gnt_t1", req_gnt, 3'b100);
        idle(1);
        cycle(1'b1, 3'b000, 6'd0, 3'b100, 1'b0, '0);
        chk("d3_ext_t3", ext_wb_gnt, 3'b000);
        cycle(1'b1, 3'b000, 6'd0, 3'b100, 1'b0, '0);
        chk("d3_ext_t4", ext_wb_gnt, 3'b100);
        chk("d3_wb_t4", wb_vld[2], 1'b1);
        idle(1);
        chk("d3_wb_t5", wb_vld[2], 1'b1);
        idle(14);

        // Iterative op on lane 0 and its occupancy window.
        cycle(1'b1, 3'b001, 6'b00_00_11, 3'b000, 1'b0, '0);
        chk("d4_gnt_t0", req_gnt, 3'b001);
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) begin
                cycle(1'b1, 3'b011, 6'b00_11_11, 3'b000, 1'b0, '0);
                chk("d4_gnt_t5", req_gnt, 3'b000);
            end else begin
                idle(1);
            end
            chk("d4_busy", iter_busy, k <= 11);
            chk("d4_wb0", wb_vld[0], k == 12);
        end
        cycle(1'b1, 3'b010, 6'b00_11_00, 3'b000, 1'b0, '0);
        chk("d4_lane1_iter", req_gnt, 3'b000);
        idle(14);

        // Flush kills LAT4 ops on all lanes.
        cycle(1'b1, 3'b111, 6'b10_10_10, 3'b000, 1'b0, '0);
        chk("d5_gnt_t0", req_gnt, 3'b111);
        idle(1);
        cycle(1'b1, 3'b111, 6'd0, 3'b111, 1'b1, '0);
        chk("d5_gnt_t2", {req_gnt, ext_wb_gnt}, 6'd0);
        cycle(1'b1, 3'b111, 6'd0, 3'b000, 1'b0, '0);
        chk("d5_gnt_t3", req_gnt, 3'b111);
        chk("d5_iss_t3", iss_vld, 3'b000);
        chk("d5_busy_t3", iter_busy, 1'b0);
        idle(1);
        chk("d5_wb_t4", wb_vld, 3'b000);
        idle(1);
        chk("d5_wb_t5", wb_vld, 3'b111);
        idle(14);

        // Async reset during an iterative op.
        cycle(1'b1, 3'b001, 6'b00_00_11, 3'b000, 1'b0, '0);
        chk("d6_gnt_t0", req_gnt, 3'b001);
        idle(2);
        cycle(1'b0, 3'b001, 6'b00_00_11, 3'b000, 1'b0, '0);
        chk("d6_busy_rst", iter_busy, 1'b0);
        chk("d6_gnt_rst", req_gnt, 3'b000);
        cycle(1'b0, 3'b001, 6'b00_00_11, 3'b000, 1'b0, '0);
        cycle(1'b1, 3'b001, 6'b00_00_11, 3'b000, 1'b0, '0);
        chk("d6_gnt_release", req_gnt, 3'b001);
        idle(16);

        // Randomized traffic against the calendar model.
        for (int n = 0; n < 2000; n++) begin
            rnd = {$urandom(), $urandom()};
            rv  = 3'($urandom_range(0, 7));
            rl  = 6'($urandom_range(0, 63));
            re  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            cycle(($urandom_range(0, 299) != 0), rv, rl, re,
                  ($urandom_range(0, 49) == 0), rnd[3*OPW-1:0]);
        end
        idle(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
